// File: rtl/spi_flash_responder.sv
// spi_flash_responder: read-only SPI NOR flash target (mode 0) serving reads from a byte-wide memory; define DUAL_READ_EN to accept 0x3B dual-output reads
module spi_flash_responder #(
  parameter int          AW       = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sclk,
  input  logic          cs_n,
  input  logic [1:0]    si,
  output logic [1:0]    so,
  output logic [1:0]    so_oe,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  input  logic [7:0]    mem_data
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ID, STAT, IGNORE} state_t;
  state_t      state;
  logic [2:0]  sclk_q, cs_q;
  logic [1:0]  si_q;
  logic [22:0] sh;
  logic [4:0]  cnt, byte_last;
  logic [7:0]  tx, pf, nb, src, op;
  logic [1:0]  id_idx;
  logic [23:0] a;
  logic        fast, dual, dual_op, rd_pend;
  logic        rise, fall, cs_hi, cs_fall, s0, out_st;
  logic        unused_si1;
  assign unused_si1 = si[1];
  assign rise      = sclk_q[1] & ~sclk_q[2];
  assign fall      = ~sclk_q[1] & sclk_q[2];
  assign cs_hi     = cs_q[1];
  assign cs_fall   = ~cs_q[1] & cs_q[2];
  assign s0        = si_q[1];
  assign op        = {sh[6:0], s0};
  assign a         = {sh, s0};
  assign byte_last = dual ? 5'd3 : 5'd7;
  assign out_st    = state == DATA || state == ID || state == STAT;
  assign nb        = state == DATA ? pf :
                     state == STAT ? STATUS :
                     id_idx == 2'd0 ? JEDEC_ID[23:16] :
                     id_idx == 2'd1 ? JEDEC_ID[15:8] :
                     id_idx == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
  assign src       = cnt == 5'd0 ? nb : tx;
`ifdef DUAL_READ_EN
  assign dual_op = op == 8'h3B;
`else
  assign dual_op = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q   <= 3'b000;
      cs_q     <= 3'b111;
      si_q     <= 2'b00;
      state    <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      tx       <= '0;
      pf       <= '0;
      id_idx   <= '0;
      fast     <= 1'b0;
      dual     <= 1'b0;
      rd_pend  <= 1'b0;
      so       <= 2'b00;
      so_oe    <= 2'b00;
      mem_addr <= '0;
      mem_rd   <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      cs_q    <= {cs_q[1:0], cs_n};
      si_q    <= {si_q[0], si[0]};
      mem_rd  <= 1'b0;
      rd_pend <= mem_rd;
      if (rd_pend) pf <= mem_data;
      if (cs_hi) begin
        state <= IDLE;
        cnt   <= '0;
        so    <= 2'b00;
        so_oe <= 2'b00;
      end else if (state == IDLE) begin
        if (cs_fall) begin
          state  <= CMD;
          cnt    <= '0;
          id_idx <= '0;
        end
      end else if (rise) begin
        sh  <= {sh[21:0], s0};
        cnt <= cnt + 5'd1;
        case (state)
          CMD: if (cnt == 5'd7) begin
            cnt   <= '0;
            fast  <= op == 8'h0B || dual_op;
            dual  <= dual_op;
            state <= op == 8'h03 || op == 8'h0B || dual_op ? ADDR :
                     op == 8'h9F ? ID : op == 8'h05 ? STAT : IGNORE;
          end
          ADDR: if (cnt == 5'd23) begin
            cnt      <= '0;
            mem_addr <= a[AW-1:0];
            mem_rd   <= 1'b1;
            state    <= fast ? DUMMY : DATA;
          end
          DUMMY: if (cnt == 5'd7) begin
            cnt   <= '0;
            state <= DATA;
          end
          DATA, ID, STAT: begin
            cnt <= cnt == byte_last ? 5'd0 : cnt + 5'd1;
            if (state == DATA && cnt == 5'd0) begin
              mem_addr <= mem_addr + AW'(1);
              mem_rd   <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (fall && out_st) begin
        so_oe <= dual ? 2'b11 : 2'b10;
        so    <= dual ? src[7:6] : {src[7], 1'b0};
        tx    <= dual ? {src[5:0], 2'b00} : {src[6:0], 1'b0};
        if (state == ID && cnt == 5'd0 && id_idx != 2'd3) id_idx <= id_idx + 2'd1;
      end
    end
  end
endmodule
